// File: rtl/sap_controller.sv
// sap_controller - T-state ring sequencer for the 8-bit SAP datapath.
// It decodes state and opcode into bus-driver enables and register load/increment strobes.
module sap_controller #(
  parameter bit         EARLY_END = 1'b0,
  parameter logic [3:0] OP_LDA    = 4'h0,
  parameter logic [3:0] OP_ADD    = 4'h1,
  parameter logic [3:0] OP_SUB    = 4'h2,
  parameter logic [3:0] OP_OUT    = 4'hE,
  parameter logic [3:0] OP_HLT    = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_en,
  output logic       pc_inc,
  output logic       mar_ld,
  output logic       mem_en,
  output logic       ir_ld,
  output logic       ir_en,
  output logic       a_ld,
  output logic       a_en,
  output logic       b_ld,
  output logic       adder_en,
  output logic       sub,
  output logic       out_ld,
  output logic       halted,
  output logic [2:0] tstate
);

  typedef enum logic [2:0] {
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_e;

  state_e state_q, state_d;

  logic is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
  logic pc_inc_raw, mar_ld_raw, ir_ld_raw, a_ld_raw, b_ld_raw, out_ld_raw;

  assign is_lda = (opcode == OP_LDA);
  assign is_add = (opcode == OP_ADD);
  assign is_sub = (opcode == OP_SUB);
  assign is_out = (opcode == OP_OUT);
  assign is_hlt = (opcode == OP_HLT);
  assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_T1;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (run && state_q != S_HALT) begin
      case (state_q)
        S_T1: state_d = S_T2;
        S_T2: state_d = S_T3;
        S_T3: state_d = S_T4;
        S_T4: begin
          if (is_hlt)                              state_d = S_HALT;
          else if (EARLY_END && (is_out || is_nop)) state_d = S_T1;
          else                                     state_d = S_T5;
        end
        S_T5: state_d = (EARLY_END && is_lda) ? S_T1 : S_T6;
        S_T6: state_d = S_T1;
        default: state_d = S_T1;
      endcase
    end
  end

  // Raw strobes are decoded first and qualified by run at the outputs.
  always_comb begin
    pc_en      = 1'b0;
    mem_en     = 1'b0;
    ir_en      = 1'b0;
    a_en       = 1'b0;
    adder_en   = 1'b0;
    sub        = 1'b0;
    pc_inc_raw = 1'b0;
    mar_ld_raw = 1'b0;
    ir_ld_raw  = 1'b0;
    a_ld_raw   = 1'b0;
    b_ld_raw   = 1'b0;
    out_ld_raw = 1'b0;
    case (state_q)
      S_T1: begin
        pc_en      = 1'b1;
        mar_ld_raw = 1'b1;
      end
      S_T2: pc_inc_raw = 1'b1;
      S_T3: begin
        mem_en    = 1'b1;
        ir_ld_raw = 1'b1;
      end
      S_T4: begin
        if (is_lda || is_add || is_sub) begin
          ir_en      = 1'b1;
          mar_ld_raw = 1'b1;
        end else if (is_out) begin
          a_en       = 1'b1;
          out_ld_raw = 1'b1;
        end
      end
      S_T5: begin
        if (is_lda) begin
          mem_en   = 1'b1;
          a_ld_raw = 1'b1;
        end else if (is_add || is_sub) begin
          mem_en   = 1'b1;
          b_ld_raw = 1'b1;
          sub      = is_sub;
        end
      end
      S_T6: begin
        if (is_add || is_sub) begin
          adder_en = 1'b1;
          a_ld_raw = 1'b1;
          sub      = is_sub;
        end
      end
      default: ;
    endcase
  end

  assign pc_inc = pc_inc_raw & run;
  assign mar_ld = mar_ld_raw & run;
  assign ir_ld  = ir_ld_raw  & run;
  assign a_ld   = a_ld_raw   & run;
  assign b_ld   = b_ld_raw   & run;
  assign out_ld = out_ld_raw & run;
  assign halted = (state_q == S_HALT);
  // HALT is entered from T4 and keeps reporting that T-state.
  assign tstate = (state_q == S_HALT) ? 3'd4 : state_q;

endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller - scoreboard bench for sap_controller.
// Stimulus pushes expected output vectors; a negedge monitor pops and compares them.
module tb_sap_controller;

  localparam logic [15:0] PCE  = 16'h8000;
  localparam logic [15:0] PCI  = 16'h4000;
  localparam logic [15:0] MAR  = 16'h2000;
  localparam logic [15:0] MEM  = 16'h1000;
  localparam logic [15:0] IRL  = 16'h0800;
  localparam logic [15:0] IRE  = 16'h0400;
  localparam logic [15:0] AL   = 16'h0200;
  localparam logic [15:0] AE   = 16'h0100;
  localparam logic [15:0] BL   = 16'h0080;
  localparam logic [15:0] ADE  = 16'h0040;
  localparam logic [15:0] SUBB = 16'h0020;
  localparam logic [15:0] OUTL = 16'h0010;
  localparam logic [15:0] HLTD = 16'h0008;

  typedef struct {
    string       name;
    logic [15:0] v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, run0, rst1_n, run1;
  logic [3:0] op0, op1;

  logic       pc_en0, pc_inc0, mar_ld0, mem_en0, ir_ld0, ir_en0, a_ld0, a_en0;
  logic       b_ld0, adder_en0, sub0, out_ld0, halted0;
  logic [2:0] tstate0;
  logic       pc_en1, pc_inc1, mar_ld1, mem_en1, ir_ld1, ir_en1, a_ld1, a_en1;
  logic       b_ld1, adder_en1, sub1, out_ld1, halted1;
  logic [2:0] tstate1;

  sap_controller #(.EARLY_END(1'b0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .run(run0), .opcode(op0),
    .pc_en(pc_en0), .pc_inc(pc_inc0), .mar_ld(mar_ld0), .mem_en(mem_en0),
    .ir_ld(ir_ld0), .ir_en(ir_en0), .a_ld(a_ld0), .a_en(a_en0), .b_ld(b_ld0),
    .adder_en(adder_en0), .sub(sub0), .out_ld(out_ld0), .halted(halted0),
    .tstate(tstate0)
  );

  sap_controller #(.EARLY_END(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .run(run1), .opcode(op1),
    .pc_en(pc_en1), .pc_inc(pc_inc1), .mar_ld(mar_ld1), .mem_en(mem_en1),
    .ir_ld(ir_ld1), .ir_en(ir_en1), .a_ld(a_ld1), .a_en(a_en1), .b_ld(b_ld1),
    .adder_en(adder_en1), .sub(sub1), .out_ld(out_ld1), .halted(halted1),
    .tstate(tstate1)
  );

  logic [15:0] vec0, vec1;
  assign vec0 = {pc_en0, pc_inc0, mar_ld0, mem_en0, ir_ld0, ir_en0, a_ld0, a_en0,
                 b_ld0, adder_en0, sub0, out_ld0, halted0, tstate0};
  assign vec1 = {pc_en1, pc_inc1, mar_ld1, mem_en1, ir_ld1, ir_en1, a_ld1, a_en1,
                 b_ld1, adder_en1, sub1, out_ld1, halted1, tstate1};

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  bit   rnd_phase = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checks++;
      if (vec0 !== e.v) begin
        errors++;
        $display("FAIL dut0 %s: got %h expected %h", e.name, vec0, e.v);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checks++;
      if (vec1 !== e.v) begin
        errors++;
        $display("FAIL dut1 %s: got %h expected %h", e.name, vec1, e.v);
      end
    end
    if (rnd_phase) begin
      checks++;
      if ($countones({pc_en0, mem_en0, ir_en0, a_en0, adder_en0}) > 1 ||
          $countones({pc_en1, mem_en1, ir_en1, a_en1, adder_en1}) > 1) begin
        errors++;
        $display("FAIL onehot: got %b / %b expected at most one driver",
                 {pc_en0, mem_en0, ir_en0, a_en0, adder_en0},
                 {pc_en1, mem_en1, ir_en1, a_en1, adder_en1});
      end
    end
  end

  task automatic cyc0(input string nm, input logic r, input logic [3:0] op, input logic [15:0] e);
    run0 = r;
    op0  = op;
    q0.push_back('{nm, e});
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input string nm, input logic r, input logic [3:0] op, input logic [15:0] e);
    run1 = r;
    op1  = op;
    q1.push_back('{nm, e});
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch0(input logic [3:0] op);
    cyc0("f_t1", 1'b1, op, PCE | MAR | 16'd1);
    cyc0("f_t2", 1'b1, op, PCI | 16'd2);
    cyc0("f_t3", 1'b1, op, MEM | IRL | 16'd3);
  endtask

  task automatic fetch1(input logic [3:0] op);
    cyc1("f_t1", 1'b1, op, PCE | MAR | 16'd1);
    cyc1("f_t2", 1'b1, op, PCI | 16'd2);
    cyc1("f_t3", 1'b1, op, MEM | IRL | 16'd3);
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    run0 = 1'b0;   run1 = 1'b0;
    op0 = 4'h0;    op1 = 4'h0;
    q0.push_back('{"rst_run0", PCE | 16'd1});
    @(negedge clk);
    #1;
    run0 = 1'b1;
    q0.push_back('{"rst_run1", PCE | MAR | 16'd1});
    @(negedge clk);
    @(posedge clk);
    #1;
    rst0_n = 1'b1; rst1_n = 1'b1;

    // LDA, full ring, back to T1 on the 7th clock
    fetch0(4'h0);
    cyc0("lda_t4", 1'b1, 4'h0, IRE | MAR | 16'd4);
    cyc0("lda_t5", 1'b1, 4'h0, MEM | AL | 16'd5);
    cyc0("lda_t6", 1'b1, 4'h0, 16'd6);

    // SUB; opcode garbage during fetch must not matter
    fetch0(4'hE);
    cyc0("sub_t4", 1'b1, 4'h2, IRE | MAR | 16'd4);
    cyc0("sub_t5", 1'b1, 4'h2, MEM | BL | SUBB | 16'd5);
    cyc0("sub_t6", 1'b1, 4'h2, ADE | AL | SUBB | 16'd6);

    // run=0 hold at T2, then OUT without early end
    cyc0("hold_t1", 1'b1, 4'hE, PCE | MAR | 16'd1);
    cyc0("hold_a", 1'b0, 4'hE, 16'd2);
    cyc0("hold_b", 1'b0, 4'hE, 16'd2);
    cyc0("hold_c", 1'b0, 4'hE, 16'd2);
    cyc0("hold_go", 1'b1, 4'hE, PCI | 16'd2);
    cyc0("hold_t3", 1'b1, 4'hE, MEM | IRL | 16'd3);
    cyc0("out_t4", 1'b1, 4'hE, AE | OUTL | 16'd4);
    cyc0("out_t5", 1'b1, 4'hE, 16'd5);
    cyc0("out_t6", 1'b1, 4'hE, 16'd6);

    // ADD, then reset asserted in the middle of T5
    fetch0(4'h1);
    cyc0("add_t4", 1'b1, 4'h1, IRE | MAR | 16'd4);
    run0 = 1'b1;
    q0.push_back('{"add_t5", MEM | BL | 16'd5});
    @(negedge clk);
    #2;
    rst0_n = 1'b0;
    q0.push_back('{"mid_rst", PCE | MAR | 16'd1});
    @(negedge clk);
    @(posedge clk);
    #1;
    rst0_n = 1'b1;
    cyc0("post_rst_t1", 1'b1, 4'h1, PCE | MAR | 16'd1);
    cyc0("post_rst_t2", 1'b1, 4'h1, PCI | 16'd2);
    cyc0("post_rst_t3", 1'b1, 4'h1, MEM | IRL | 16'd3);
    cyc0("post_rst_t4", 1'b1, 4'h1, IRE | MAR | 16'd4);
    cyc0("post_rst_t5", 1'b1, 4'h1, MEM | BL | 16'd5);
    cyc0("add_t6", 1'b1, 4'h1, ADE | AL | 16'd6);

    // HLT: sticky, run ignored, reset exits
    fetch0(4'hF);
    cyc0("hlt_t4", 1'b1, 4'hF, 16'd4);
    for (int i = 0; i < 12; i++) begin
      cyc0("halt", 1'(i % 2), 4'(i), HLTD | 16'd4);
    end
    rst0_n = 1'b0;
    #2;
    rst0_n = 1'b1;
    cyc0("unhalt_t1", 1'b1, 4'h0, PCE | MAR | 16'd1);
    run0 = 1'b0;

    // EARLY_END=1: OUT, NOP and LDA return early
    fetch1(4'hE);
    cyc1("e_out_t4", 1'b1, 4'hE, AE | OUTL | 16'd4);
    fetch1(4'h5);
    cyc1("e_nop_t4", 1'b1, 4'h5, 16'd4);
    fetch1(4'h0);
    cyc1("e_lda_t4", 1'b1, 4'h0, IRE | MAR | 16'd4);
    cyc1("e_lda_t5", 1'b1, 4'h0, MEM | AL | 16'd5);
    fetch1(4'h2);
    cyc1("e_sub_t4", 1'b1, 4'h2, IRE | MAR | 16'd4);
    cyc1("e_sub_t5", 1'b1, 4'h2, MEM | BL | SUBB | 16'd5);
    cyc1("e_sub_t6", 1'b1, 4'h2, ADE | AL | SUBB | 16'd6);
    cyc1("e_end_t1", 1'b1, 4'h2, PCE | MAR | 16'd1);

    // random opcode/run stream with occasional resets
    rnd_phase = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      run0   = 1'($urandom);
      run1   = 1'($urandom);
      op0    = 4'($urandom);
      op1    = 4'($urandom);
      rst0_n = ($urandom_range(0, 40) != 0);
      rst1_n = ($urandom_range(0, 40) != 0);
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    rnd_phase = 1'b0;

    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q0.size() + q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
